// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Brief    : Shared types and width helpers for the single-channel DMA.
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } dma_rd_state_t;

   function automatic int burstcount_width(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dma_burst_read_master_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_read_master_if
// Brief    : Avalon-MM burst read bus plus streaming source of the DMA reader.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_burst_read_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BURST  = 16
);
   localparam int c_bcw = dma_pkg::burstcount_width(MAX_BURST);

   logic [ADDR_WIDTH-1:0] amm_address_o;
   logic                  amm_read_o;
   logic [c_bcw-1:0]      amm_burstcount_o;
   logic                  amm_waitrequest_i;
   logic [DATA_WIDTH-1:0] amm_readdata_i;
   logic                  amm_readdatavalid_i;
   logic [DATA_WIDTH-1:0] st_data_o;
   logic                  st_valid_o;
   logic                  st_ready_i;

   modport master (
      output amm_address_o, amm_read_o, amm_burstcount_o, st_data_o, st_valid_o,
      input  amm_waitrequest_i, amm_readdata_i, amm_readdatavalid_i, st_ready_i
   );

   modport slave (
      input  amm_address_o, amm_read_o, amm_burstcount_o, st_data_o, st_valid_o,
      output amm_waitrequest_i, amm_readdata_i, amm_readdatavalid_i, st_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/sc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sc_fifo
// Brief    : Single-clock FIFO with registered output word (show-ahead).
// Revision : 1.0 - initial release
// ============================================================================
module sc_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int WORDS_AMOUNT = 64,
   localparam int c_aw = $clog2(WORDS_AMOUNT),
   localparam int c_cw = c_aw + 1
)(
   input  wire logic                  clk_i,
   input  wire logic                  rst_i,
   input  wire logic                  wr_i,
   input  wire logic [DATA_WIDTH-1:0] data_i,
   input  wire logic                  rd_i,
   output logic      [DATA_WIDTH-1:0] data_o,
   output logic                       valid_o,
   output logic      [c_cw-1:0]       used_words_o
);
   logic [DATA_WIDTH-1:0] r_mem [WORDS_AMOUNT];
   logic [c_aw-1:0]       r_wr_ptr, r_rd_ptr;
   logic [c_cw-1:0]       r_mem_cnt;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  w_wr, w_load;

   assign w_wr   = wr_i && (r_mem_cnt != c_cw'(WORDS_AMOUNT));
   // Refill the output word whenever it is empty or being consumed.
   assign w_load = (r_mem_cnt != '0) && (!r_out_valid || rd_i);

   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_mem_cnt   <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_wr)   r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_load) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_out_data <= r_mem[r_rd_ptr];
         end
         r_mem_cnt <= r_mem_cnt + c_cw'(w_wr) - c_cw'(w_load);
         if (w_load)     r_out_valid <= 1'b1;
         else if (rd_i)  r_out_valid <= 1'b0;
      end
   end

   assign data_o       = r_out_data;
   assign valid_o      = r_out_valid;
   assign used_words_o = r_mem_cnt + c_cw'(r_out_valid);
endmodule
`default_nettype wire

// File: rtl/dma_burst_read_master.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_read_master
// Brief    : Credit-based Avalon-MM burst reader feeding a streaming source.
//            Define DMA_READ_BOUNDARY_EN to keep bursts inside aligned blocks.
// Revision : 1.0 - initial release
// ============================================================================
module dma_burst_read_master
   import dma_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 64
)(
   input  wire logic                 clk_i,
   input  wire logic                 rst_i,
   input  wire logic                 start_i,
   input  wire logic [ADDR_WIDTH-1:0] base_addr_i,
   input  wire logic [LEN_WIDTH-1:0]  length_i,
   output logic                      busy_o,
   output logic                      done_o,
   dma_burst_read_master_if.master   bus
);
   localparam int c_bcw     = burstcount_width(MAX_BURST);
   localparam int c_cw      = $clog2(FIFO_DEPTH) + 1;
   localparam int c_sw      = c_cw + 2;
   localparam int c_bpw_log = $clog2(bytes_per_word(DATA_WIDTH));
   localparam int c_mb_log  = $clog2(MAX_BURST);

   dma_rd_state_t         r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_next_addr, w_cand_addr, r_addr;
   logic [LEN_WIDTH-1:0]  r_words_left, w_cand_words;
   logic [c_cw-1:0]       r_outst, w_used_words;
   logic [c_bcw-1:0]      r_bc, w_cand_bc;
   logic [c_sw-1:0]       w_credit_sum;
   logic [DATA_WIDTH-1:0] w_fifo_data;
   logic                  r_read, r_done, w_done_nxt;
   logic                  w_accept, w_hold, w_rdv, w_pop, w_credit, w_req, w_fifo_valid;
`ifdef DMA_READ_BOUNDARY_EN
   logic [c_bcw-1:0]      w_room;
`endif

   assign w_accept = r_read & ~bus.amm_waitrequest_i;
   assign w_hold   = r_read &  bus.amm_waitrequest_i;
   assign w_rdv    = bus.amm_readdatavalid_i & (r_state != IDLE);
   assign w_pop    = w_fifo_valid & bus.st_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Candidate address/length are the values after this cycle's acceptance.
   always_comb begin
      w_state_nxt  = r_state;
      w_done_nxt   = 1'b0;
      w_cand_words = r_words_left;
      w_cand_addr  = r_next_addr;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_cand_words = length_i;
               w_cand_addr  = base_addr_i;
               if (length_i != '0) w_state_nxt = ISSUE;
               else                w_done_nxt  = 1'b1;
            end
         end
         ISSUE: begin
            if (w_accept) begin
               w_cand_words = r_words_left - LEN_WIDTH'(r_bc);
               w_cand_addr  = r_next_addr + (ADDR_WIDTH'(r_bc) << c_bpw_log);
               if (w_cand_words == '0) w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if ((r_outst == '0) && w_pop && (w_used_words == c_cw'(1))) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      if (w_cand_words >= LEN_WIDTH'(MAX_BURST)) w_cand_bc = c_bcw'(MAX_BURST);
      else                                       w_cand_bc = w_cand_words[c_bcw-1:0];
`ifdef DMA_READ_BOUNDARY_EN
      w_room = c_bcw'(MAX_BURST) - c_bcw'(w_cand_addr[c_bpw_log +: c_mb_log]);
      if (w_room < w_cand_bc) w_cand_bc = w_room;
`endif
   end

   // used + outstanding is conserved by data returns; only pops release credit.
   assign w_credit_sum = c_sw'(w_used_words) + c_sw'(r_outst)
                       + (w_accept ? c_sw'(r_bc) : c_sw'(0)) + c_sw'(w_cand_bc);
   assign w_credit     = (w_credit_sum <= c_sw'(FIFO_DEPTH));
   assign w_req        = (w_state_nxt == ISSUE) && (w_cand_words != '0) && w_credit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_next_addr  <= '0;
         r_words_left <= '0;
         r_outst      <= '0;
         r_read       <= 1'b0;
         r_addr       <= '0;
         r_bc         <= '0;
         r_done       <= 1'b0;
      end else begin
         r_next_addr  <= w_cand_addr;
         r_words_left <= w_cand_words;
         r_done       <= w_done_nxt;
         r_outst      <= r_outst + (w_accept ? c_cw'(r_bc) : c_cw'(0)) - c_cw'(w_rdv);
         if (!w_hold) begin
            r_read <= w_req;
            r_addr <= w_cand_addr;
            r_bc   <= w_cand_bc;
         end
      end
   end

   sc_fifo #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WORDS_AMOUNT (FIFO_DEPTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_i         (w_rdv),
      .data_i       (bus.amm_readdata_i),
      .rd_i         (w_pop),
      .data_o       (w_fifo_data),
      .valid_o      (w_fifo_valid),
      .used_words_o (w_used_words)
   );

   assign bus.amm_address_o    = r_addr;
   assign bus.amm_read_o       = r_read;
   assign bus.amm_burstcount_o = r_bc;
   assign bus.st_data_o        = w_fifo_data;
   assign bus.st_valid_o       = w_fifo_valid;
   assign busy_o               = (r_state != IDLE);
   assign done_o               = r_done;
endmodule
`default_nettype wire

// File: doc/dma_burst_read_master.md
# dma_burst_read_master

Avalon-MM burst read master for the single-channel DMA: the read-side counterpart of the DMA write path. It fetches a programmed block of words from memory using dynamically sized bursts and buffers the returned data in an internal `sc_fifo`. It presents that data on a ready/valid streaming source feeding the write path. Bursts are issued only when FIFO space is guaranteed, so `readdatavalid` never needs backpressure.

## Interface
- `DATA_WIDTH`, 32: data word width, in bits; power of two and ≥ 8.
- `ADDR_WIDTH`, 32: Avalon byte-address width.
- `LEN_WIDTH`, 16: width of the transfer length, in words.
- `MAX_BURST`, 16: maximum burst length, in words; power of two.
- `FIFO_DEPTH`, 64: buffer capacity, in words; power of two and ≥ `MAX_BURST`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle command strobe, sampled only in IDLE.
- `base_addr_i` in `ADDR_WIDTH`: start byte address; must be word-aligned.
- `length_i` in `LEN_WIDTH`: number of words to transfer.
- `busy_o` out 1: high from the accepted start until `done_o`.
- `done_o` out 1: one-cycle pulse when the last word leaves the stream port.
- `amm_address_o` out `ADDR_WIDTH`: burst start byte address.
- `amm_read_o` out 1: read request.
- `amm_burstcount_o` out `$clog2(MAX_BURST)+1`: burst length.
- `amm_waitrequest_i` in 1: slave stall.
- `amm_readdata_i` in `DATA_WIDTH`: read data.
- `amm_readdatavalid_i` in 1: read data valid.
- `st_data_o` out `DATA_WIDTH`: stream data.
- `st_valid_o` out 1: stream valid.
- `st_ready_i` in 1: stream ready.

## Operation
- State machine IDLE → ISSUE → DRAIN → IDLE.
  - IDLE: on `start_i`, latch the address and length into `next_addr` and `words_left`. Go to ISSUE if `length_i` > 0. If `length_i` = 0, pulse `done_o` next cycle and stay in IDLE.
  - ISSUE: drive one burst at a time. When `words_left` reaches 0 after an accepted request, go to DRAIN.
  - DRAIN: wait until `outstanding` = 0 and the FIFO is empty. On the cycle the last word is popped, pulse `done_o` and return to IDLE.
- Burst size `bc` = min(`MAX_BURST`, `words_left`), truncated further as described under Configuration.
- Credit rule: a burst is raised only if `used_words` + `outstanding` + `bc` ≤ `FIFO_DEPTH`. Otherwise `amm_read_o` stays low.
- A request is accepted when `amm_read_o` is high and `amm_waitrequest_i` is low. On acceptance:
  - `outstanding` increases by `bc`.
  - `words_left` decreases by `bc`.
  - `next_addr` increases by `bc*DATA_WIDTH/8`, modulo 2^`ADDR_WIDTH`.
- Each `amm_readdatavalid_i` decrements `outstanding` by 1 and writes `amm_readdata_i` into the FIFO. A same-cycle acceptance and data return apply both updates, net `bc`−1.
- `outstanding` width is `$clog2(FIFO_DEPTH)+1`. It can never overflow, because of the credit rule.
- Stream side: `st_valid_o` = FIFO not empty; `st_data_o` = FIFO output. A FIFO pop occurs when `st_valid_o` and `st_ready_i` are both high.
- `start_i` is ignored while `busy_o` is high.
- `readdatavalid` arriving in IDLE (stray data after a reset) is discarded, not written.
- Reset mid-operation returns the block to IDLE immediately and clears all counters and the FIFO.

## Timing
- Reset values:
  - `busy_o`, `done_o`, `amm_read_o`, `st_valid_o` = 0.
  - `amm_address_o` = 0; `amm_burstcount_o` = 0.
  - `st_data_o` is undefined.
- `start_i` in cycle N gives `busy_o` = 1 and the first `amm_read_o` in cycle N+1, when credit allows.
- `amm_address_o` and `amm_burstcount_o` are registered and held stable while `amm_waitrequest_i` is high.
- Back-to-back bursts are allowed: the next request may be raised in the cycle after acceptance.
- FIFO latency: a word written in cycle M is visible on `st_valid_o` in cycle M+2, due to the `sc_fifo` output register.
- `done_o` is registered and asserted in the cycle after the final pop; `busy_o` falls in the same cycle.

## Configuration
- `DMA_READ_BOUNDARY_EN` defined: each burst is truncated so it does not cross a `MAX_BURST*DATA_WIDTH/8`-byte aligned boundary. An unaligned start therefore produces a short first burst.
- Without the macro, bursts use only the min(`MAX_BURST`, `words_left`) rule.

## Structure
- The shared package `dma_pkg` holds:
  - the state enum `dma_rd_state_t` (IDLE, ISSUE, DRAIN);
  - the `burstcount` width function;
  - the bytes-per-word constant computation.
- Sub-module: the existing `sc_fifo`, instantiated with `WORDS_AMOUNT = FIFO_DEPTH`. Its `used_words_o` feeds the credit rule.

## Test plan
- Basic transfer: `base` = 0x1000, `length` = 40, `MAX_BURST` = 16, ready always high.
  - Expect bursts 16/16/8 at addresses 0x1000/0x1040/0x1080.
  - Expect 40 words in order, then a single `done_o` pulse.
- Stream backpressure: `st_ready_i` = 0, `length` = 200, `FIFO_DEPTH` = 64.
  - Expect no more than 64 words requested.
  - Expect no further `amm_read_o` until a pop frees 16 slots.
- Random stall: `amm_waitrequest_i` random 50%.
  - Expect address and burstcount to hold while stalled.
  - Expect the total burstcount to equal `length`.
- Boundary: with `DMA_READ_BOUNDARY_EN`, `base` = 0x1038, `length` = 20.
  - Expect bursts 2/16/2.
  - Without the macro, expect bursts 16/4.
- Zero length: `length` = 0 → `done_o` pulse one cycle later, no `amm_read_o`.
- Reset mid-transfer:
  - Assert `rst_i` during a burst → all outputs return to their reset values.
  - Stray `readdatavalid` afterwards → not delivered to the stream.
  - A new start afterwards → completes correctly.
